rtc_read_sequencer: RTL and testbench

//  Parametrised RTC read sequencer: on start, issues a transfer command (clock or timer

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/rtc_read_sequencer_if.sv | 26 ++
 rtl/rtc_bcd_check.sv | 21 ++
 rtl/rtc_read_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read sequencer: FSM state encoding,
// default bus command constants and the index-width helper.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [7:0] RTC_CMD_CLK  = 8'hF1;
    localparam logic [7:0] RTC_CMD_TMR  = 8'hF2;
    localparam logic [7:0] RTC_CMD_DATA = 8'h01;

    // Index counter width; a single-register table still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Phase handshake between the RTC read sequencer (master) and the RTC bus driver (slave).
interface rtc_read_sequencer_if #(
    parameter int DW = 8
);
    logic          ph_addr;
    logic          ph_data;
    logic          ph_done;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] bus_addr;

    modport master (
        input  ph_addr,
        input  ph_data,
        input  ph_done,
        input  rd_data,
        output bus_addr
    );

    modport slave (
        output ph_addr,
        output ph_data,
        output ph_done,
        output rd_data,
        input  bus_addr
    );
endinterface

// File: rtl/rtc_bcd_check.sv
// Combinational BCD validator: flags any full nibble of data above 9.
// Only compiled when RTC_BCD_CHECK_EN is defined.
`ifdef RTC_BCD_CHECK_EN
module rtc_bcd_check #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] data,
    output logic          bad
);
    localparam int NIB = DW / 4;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            if (data[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/rtc_read_sequencer.sv
// RTC read sequencer: issues a clock/timer transfer command, then reads a programmable
// register list through the phase handshake. Optional sticky BCD check: RTC_BCD_CHECK_EN.
module rtc_read_sequencer
    import rtc_pkg::*;
#(
    parameter int            DW       = 8,
    parameter int            NUM_REGS = 6,
    parameter int            NUM_TMR  = 3,
    parameter logic [DW-1:0] CMD_CLK  = DW'(RTC_CMD_CLK),
    parameter logic [DW-1:0] CMD_TMR  = DW'(RTC_CMD_TMR),
    parameter logic [DW-1:0] CMD_DATA = DW'(RTC_CMD_DATA)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode_tmr,
    input  logic                   abort,
    rtc_read_sequencer_if.master   bus,
    input  logic [NUM_REGS*DW-1:0] addr_tab,
    output logic                   busy,
    output logic                   done,
`ifdef RTC_BCD_CHECK_EN
    output logic                   bcd_err,
`endif
    output logic [NUM_REGS*DW-1:0] regs_q
);
    localparam int            IW       = idx_width(NUM_REGS);
    localparam logic [IW-1:0] LAST_CLK = IW'(NUM_REGS - 1);
    localparam logic [IW-1:0] LAST_TMR = IW'(NUM_TMR - 1);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [DW-1:0]          bus_addr_q, bus_addr_d;
    logic [NUM_REGS*DW-1:0] reg_file_q, reg_file_d;
    logic [IW-1:0]          last_idx;

`ifdef RTC_BCD_CHECK_EN
    logic bcd_err_q, bcd_err_d;
    logic bcd_bad;

    rtc_bcd_check #(.DW(DW)) u_bcd_check (
        .data (bus.rd_data),
        .bad  (bcd_bad)
    );
`endif

    assign last_idx = mode_q ? LAST_TMR : LAST_CLK;

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bus_addr_d = bus_addr_q;
        reg_file_d = reg_file_q;
`ifdef RTC_BCD_CHECK_EN
        bcd_err_d  = bcd_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                bus_addr_d = '1;
                if (start) begin
                    state_d = CMD;
                    busy_d  = 1'b1;
                    mode_d  = mode_tmr;
                    idx_d   = '0;
`ifdef RTC_BCD_CHECK_EN
                    bcd_err_d = 1'b0;
`endif
                end
            end
            CMD: begin
                if (bus.ph_addr) begin
                    bus_addr_d = mode_q ? CMD_TMR : CMD_CLK;
                end else if (bus.ph_data) begin
                    bus_addr_d = CMD_DATA;
                end else if (bus.ph_done) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.ph_addr) begin
                    bus_addr_d = addr_tab[idx_q*DW +: DW];
                end else if (bus.ph_data) begin
                    reg_file_d[idx_q*DW +: DW] = bus.rd_data;
`ifdef RTC_BCD_CHECK_EN
                    bcd_err_d = bcd_err_q | bcd_bad;
`endif
                end else if (bus.ph_done) begin
                    if (idx_q == last_idx) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        bus_addr_d = '1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                bus_addr_d = '1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the strobes did this cycle; captured data is kept.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            idx_d      = '0;
            bus_addr_d = '1;
            reg_file_d = reg_file_q;
`ifdef RTC_BCD_CHECK_EN
            bcd_err_d  = bcd_err_q;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_addr_q <= '1;
            // NOTE: the capture array is reset because its contents are visible on regs_q.
            reg_file_q <= '0;
`ifdef RTC_BCD_CHECK_EN
            bcd_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_addr_q <= bus_addr_d;
            reg_file_q <= reg_file_d;
`ifdef RTC_BCD_CHECK_EN
            bcd_err_q  <= bcd_err_d;
`endif
        end
    end

    assign bus.bus_addr = bus_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign regs_q       = reg_file_q;
`ifdef RTC_BCD_CHECK_EN
    assign bcd_err      = bcd_err_q;
`endif

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Randomised bench for rtc_read_sequencer against a transaction-level model of the
// command/read sequence, abort, reset and (with RTC_BCD_CHECK_EN) the sticky BCD flag.
module tb_rtc_read_sequencer;
    localparam int DW = 8;
    localparam int N  = 6;
    localparam int NT = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            mode_tmr;
    logic            abort;
    logic [N*DW-1:0] addr_tab;
    logic            busy;
    logic            done;
    logic [N*DW-1:0] regs_q;
`ifdef RTC_BCD_CHECK_EN
    logic            bcd_err;
`endif

    rtc_read_sequencer_if #(.DW(DW)) bus ();

    rtc_read_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode_tmr (mode_tmr),
        .abort    (abort),
        .bus      (bus),
        .addr_tab (addr_tab),
        .busy     (busy),
        .done     (done),
`ifdef RTC_BCD_CHECK_EN
        .bcd_err  (bcd_err),
`endif
        .regs_q   (regs_q)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register contents, sticky BCD flag, word last shown on the bus.
    logic [7:0] m_regs [N];
    bit         m_bcd;
    logic [7:0] exp_ba;
    logic [7:0] tab [N];
    logic [7:0] dat [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] model_regs();
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = m_regs[i];
        return p;
    endfunction

    function automatic bit not_bcd(input logic [7:0] v);
        return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        bus.ph_addr = 1'b0;
        bus.ph_data = 1'b0;
        bus.ph_done = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic check_bcd(input string tag);
`ifdef RTC_BCD_CHECK_EN
        check(tag, 64'(bcd_err), 64'(m_bcd));
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_bus_addr"}, 64'(bus.bus_addr), 64'hFF);
        check({tag, "_regs"}, 64'(regs_q), 64'(model_regs()));
        check_bcd({tag, "_bcd"});
    endtask

    // Idle cycles mid-sequence, sometimes with a start that must be ignored.
    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            start    = 1'($urandom_range(0, 1));
            mode_tmr = 1'($urandom);
            tick();
            start = 1'b0;
            check("gap_busy", 64'(busy), 64'd1);
            check("gap_bus_addr", 64'(bus.bus_addr), 64'(exp_ba));
        end
    endtask

    // One full sequence. Step k: k/3-1 = read index (-1 = command), k%3 = addr/data/done phase.
    // kill_at selects a step where abort (or reset) is raised together with that step's strobes.
    task automatic run_seq(input bit mode, input int kill_at, input bit kill_reset);
        int last;
        int nsteps;
        int ph;
        int r;
        last   = mode ? NT - 1 : N - 1;
        nsteps = 3 + 3 * (last + 1);
        for (int i = 0; i < N; i++) addr_tab[i*DW +: DW] = tab[i];

        start    = 1'b1;
        mode_tmr = mode;
        tick();
        start    = 1'b0;
        mode_tmr = ~mode;
        m_bcd    = 1'b0;
        exp_ba   = 8'hFF;
        check("start_busy", 64'(busy), 64'd1);
        check("start_done", 64'(done), 64'd0);
        check_bcd("start_bcd_clear");

        for (int step = 0; step < nsteps; step++) begin
            gap();
            ph = step % 3;
            r  = step / 3 - 1;
            bus.rd_data = 8'($urandom);
            case (ph)
                0: begin
                    bus.ph_addr = 1'b1;
                    bus.ph_data = 1'($urandom);
                    bus.ph_done = 1'($urandom);
                end
                1: begin
                    bus.ph_data = 1'b1;
                    bus.ph_done = 1'($urandom);
                    if (r >= 0) bus.rd_data = dat[r];
                end
                default: bus.ph_done = 1'b1;
            endcase

            if (step == kill_at) begin
                if (kill_reset) reset = 1'b1;
                else            abort = 1'b1;
                tick();
                clear_strobes();
                reset = 1'b0;
                if (kill_reset) begin
                    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
                    m_bcd = 1'b0;
                end
                check("kill_busy", 64'(busy), 64'd0);
                check("kill_done", 64'(done), 64'd0);
                tick();
                check_idle("kill_after");
                return;
            end

            tick();
            clear_strobes();
            if (ph == 0) begin
                exp_ba = (r < 0) ? (mode ? 8'hF2 : 8'hF1) : tab[r];
            end else if (ph == 1) begin
                if (r < 0) begin
                    exp_ba = 8'h01;
                end else begin
                    m_regs[r] = dat[r];
                    m_bcd     = m_bcd | not_bcd(dat[r]);
                end
            end

            if (step == nsteps - 1) begin
                check("done_pulse", 64'(done), 64'd1);
                check("done_busy", 64'(busy), 64'd0);
                check("done_bus_addr", 64'(bus.bus_addr), 64'hFF);
                check("done_regs", 64'(regs_q), 64'(model_regs()));
                start = 1'($urandom);
                tick();
                start = 1'b0;
                check("after_done_pulse", 64'(done), 64'd0);
                tick();
                check_idle("after_done_idle");
            end else begin
                check("step_busy", 64'(busy), 64'd1);
                check("step_done", 64'(done), 64'd0);
                check("step_bus_addr", 64'(bus.bus_addr), 64'(exp_ba));
                check_bcd("step_bcd");
            end
        end
    endtask

    function automatic logic [7:0] rand_data();
        if ($urandom_range(0, 1) == 0)
            return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        return 8'($urandom);
    endfunction

    initial begin
        clear_strobes();
        reset       = 1'b1;
        mode_tmr    = 1'b0;
        bus.rd_data = '0;
        addr_tab    = '0;
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_bcd = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_idle("reset_state");

        tab[0] = 8'h00; tab[1] = 8'h01; tab[2] = 8'h02;
        tab[3] = 8'h24; tab[4] = 8'h25; tab[5] = 8'h26;

        // Clock mode, spec table and data.
        for (int i = 0; i < N; i++) dat[i] = 8'h10 + 8'(i);
        run_seq(1'b0, -1, 1'b0);
        check("clk_mode_regs", 64'(regs_q), 64'h15_14_13_12_11_10);

        // Timer mode: only entries 0..2 change.
        for (int i = 0; i < N; i++) dat[i] = 8'h20 + 8'(i);
        run_seq(1'b1, -1, 1'b0);
        check("tmr_mode_regs", 64'(regs_q), 64'h15_14_13_22_21_20);

        // Abort on the third read's address phase (after two complete reads).
        for (int i = 0; i < N; i++) dat[i] = 8'h30 + 8'(i);
        run_seq(1'b0, 9, 1'b0);
        check("abort_regs", 64'(regs_q), 64'h15_14_13_22_31_30);

        // Reset during the first read's data phase, then a clean sequence.
        run_seq(1'b0, 4, 1'b1);
        check("reset_mid_regs", 64'(regs_q), 64'h0);
        for (int i = 0; i < N; i++) dat[i] = 8'h40 + 8'(i);
        run_seq(1'b0, -1, 1'b0);

`ifdef RTC_BCD_CHECK_EN
        for (int i = 0; i < N; i++) dat[i] = 8'h59;
        run_seq(1'b0, -1, 1'b0);
        check("bcd_valid_59", 64'(bcd_err), 64'd0);
        dat[2] = 8'h5A;
        run_seq(1'b0, -1, 1'b0);
        check("bcd_bad_5a", 64'(bcd_err), 64'd1);
`endif

        repeat (40) begin
            int  kill_at;
            bit  kill_reset;
            for (int i = 0; i < N; i++) begin
                tab[i] = 8'($urandom);
                dat[i] = rand_data();
            end
            kill_at    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            kill_reset = ($urandom_range(0, 3) == 0);
            run_seq(1'($urandom), kill_at, kill_reset);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
